scl_en_decim: RTL and testbench

- Parametrised data-enable delay-and-decimation block for the scaler output path.
- Delays the incoming pixel enable by DLY cycles and exposes early taps for downstream pipeline alignment.
- Decimates the delayed enable horizontally (keeps 1 of 1/2/4/8 pixels at a selectable phase) and vertically (keeps 1 of 1/2/4/8 lines).
- Configuration is shadowed so it only changes between lines.

---
 rtl/scl_en_decim_pkg.sv | 36 +++
 rtl/scl_en_decim_dly.sv | 31 +++
 rtl/scl_en_decim.sv | 94 +++++++++
 tb/tb_scl_en_decim.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/scl_en_decim_pkg.sv
// ============================================================================
// Module : scl_pkg
// Brief  : Shared widths, ratio encodings and mask helper for scl_en_decim.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scl_pkg;

  localparam int SCL_CNT_W   = 3;
  localparam int SCL_RATIO_W = 2;

  typedef enum logic [SCL_RATIO_W-1:0] {
    SCL_R1 = 2'd0,
    SCL_R2 = 2'd1,
    SCL_R4 = 2'd2,
    SCL_R8 = 2'd3
  } scl_ratio_e;

  // Low-bit mask selecting the position within a 2^ratio group.
  function automatic logic [SCL_CNT_W-1:0] scl_ratio_mask(input logic [SCL_RATIO_W-1:0] ratio);
    logic [SCL_CNT_W-1:0] m;
    m = 3'b000;
    case (ratio)
      SCL_R1:  m = 3'b000;
      SCL_R2:  m = 3'b001;
      SCL_R4:  m = 3'b011;
      SCL_R8:  m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scl_en_decim_dly.sv
// ============================================================================
// Module : scl_en_dly
// Brief  : DLY-deep enable shift register with early tap outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scl_en_dly #(
  parameter int DLY  = 6,
  parameter int TAPS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_in,
  output logic            en_dly,
  output logic [TAPS-1:0] en_tap
);

  logic [DLY-1:0] r_en_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_en_d <= '0;
    else      r_en_d <= {r_en_d[DLY-2:0], en_in};
  end

  assign en_dly = r_en_d[DLY-1];
  assign en_tap = r_en_d[TAPS-1:0];

endmodule

`default_nettype wire

// File: rtl/scl_en_decim.sv
// ============================================================================
// Module : scl_en_decim
// Brief  : Enable delay plus horizontal/vertical decimation with line-shadowed config.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scl_en_decim
  import scl_pkg::*;
#(
  parameter int DLY  = 6,
  parameter int TAPS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scl_i_data_en,
  input  logic                   scl_i_frame_start,
  input  logic                   scl_cfg_mode,
  input  logic [SCL_RATIO_W-1:0] scl_cfg_hratio,
  input  logic [SCL_CNT_W-1:0]   scl_cfg_hphase,
  input  logic [SCL_RATIO_W-1:0] scl_cfg_vratio,
  output logic                   scl_o_data_en,
  output logic [TAPS-1:0]        en_tap,
  output logic                   scl_o_line_end,
  output logic                   scl_o_line_keep
);

  logic                   w_en_dly;
  logic                   r_en_dly_q;
  logic                   r_mode;
  logic [SCL_RATIO_W-1:0] r_hratio;
  logic [SCL_CNT_W-1:0]   r_hphase;
  logic [SCL_RATIO_W-1:0] r_vratio;
  logic [SCL_CNT_W-1:0]   r_hcnt;
  logic [SCL_CNT_W-1:0]   r_vcnt;

  logic [SCL_CNT_W-1:0]   w_hmask;
  logic [SCL_CNT_W-1:0]   w_vmask;
  logic [SCL_CNT_W-1:0]   w_phase;
  logic                   w_line_end;
  logic                   w_line_keep;
  logic                   w_pix_keep;

  scl_en_dly #(
    .DLY  (DLY),
    .TAPS (TAPS)
  ) u_dly (
    .clk    (clk),
    .rst    (rst),
    .en_in  (scl_i_data_en),
    .en_dly (w_en_dly),
    .en_tap (en_tap)
  );

  assign w_hmask     = scl_ratio_mask(r_hratio);
  assign w_vmask     = scl_ratio_mask(r_vratio);
  assign w_phase     = r_hphase & w_hmask;
  assign w_line_end  = !w_en_dly && r_en_dly_q;
  assign w_line_keep = !r_mode || (r_vratio == SCL_R1) || ((r_vcnt & w_vmask) == 3'd0);
  assign w_pix_keep  = !r_mode || ((r_hcnt & w_hmask) == w_phase);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_dly_q      <= 1'b0;
      r_mode          <= 1'b0;
      r_hratio        <= '0;
      r_hphase        <= '0;
      r_vratio        <= '0;
      r_hcnt          <= '0;
      r_vcnt          <= '0;
      scl_o_data_en   <= 1'b0;
      scl_o_line_end  <= 1'b0;
      scl_o_line_keep <= 1'b0;
    end else begin
      r_en_dly_q <= w_en_dly;
      // Config only follows the ports between delayed lines.
      if (!w_en_dly) begin
        r_mode   <= scl_cfg_mode;
        r_hratio <= scl_cfg_hratio;
        r_hphase <= scl_cfg_hphase;
        r_vratio <= scl_cfg_vratio;
      end
      r_hcnt <= w_en_dly ? r_hcnt + 3'd1 : 3'd0;
      if (scl_i_frame_start) r_vcnt <= 3'd0;
      else if (w_line_end)   r_vcnt <= r_vcnt + 3'd1;
      scl_o_data_en   <= w_en_dly && w_line_keep && w_pix_keep;
      scl_o_line_end  <= w_line_end;
      scl_o_line_keep <= w_line_keep;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scl_en_decim.sv
// ============================================================================
// Module : tb_scl_en_decim
// Brief  : Directed line-vector bench for scl_en_decim (DLY=6, TAPS=4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scl_en_decim;

  localparam int DLY  = 6;
  localparam int TAPS = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            scl_i_data_en = 1'b0;
  logic            scl_i_frame_start = 1'b0;
  logic            scl_cfg_mode = 1'b0;
  logic [1:0]      scl_cfg_hratio = '0;
  logic [2:0]      scl_cfg_hphase = '0;
  logic [1:0]      scl_cfg_vratio = '0;
  logic            scl_o_data_en;
  logic [TAPS-1:0] en_tap;
  logic            scl_o_line_end;
  logic            scl_o_line_keep;

  int n_tests = 0;
  int n_fail  = 0;

  scl_en_decim #(.DLY(DLY), .TAPS(TAPS)) dut (
    .clk               (clk),
    .rst               (rst),
    .scl_i_data_en     (scl_i_data_en),
    .scl_i_frame_start (scl_i_frame_start),
    .scl_cfg_mode      (scl_cfg_mode),
    .scl_cfg_hratio    (scl_cfg_hratio),
    .scl_cfg_hphase    (scl_cfg_hphase),
    .scl_cfg_vratio    (scl_cfg_vratio),
    .scl_o_data_en     (scl_o_data_en),
    .en_tap            (en_tap),
    .scl_o_line_end    (scl_o_line_end),
    .scl_o_line_keep   (scl_o_line_keep)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  hr;
    logic [2:0]  hp;
    logic [1:0]  vr;
    logic        fs_pre;
    int          fs_t;
    int          chg_t;
    logic [1:0]  chg_hr;
    int          len;
    logic [31:0] exp_mask;
    logic        exp_keep;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic mode, input logic [1:0] hr, input logic [2:0] hp,
                              input logic [1:0] vr, input logic fsp, input int fst, input int len,
                              input logic [31:0] mask, input logic keep);
    vec_t v;
    v.mode = mode; v.hr = hr; v.hp = hp; v.vr = vr; v.fs_pre = fsp; v.fs_t = fst;
    v.chg_t = -1; v.chg_hr = 2'd0; v.len = len; v.exp_mask = mask; v.exp_keep = keep;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", nm, id, act, exp);
    end
  endtask

  // Drives one line, then idles long enough for the delayed line to drain.
  task automatic run_line(input vec_t v, input int id);
    logic [31:0] mask;
    int stray, le_cnt, le_t, tap_err, j;
    logic keep_s;
    mask = '0; stray = 0; le_cnt = 0; le_t = -1; tap_err = 0; keep_s = 1'bx;
    scl_cfg_mode = v.mode; scl_cfg_hratio = v.hr; scl_cfg_hphase = v.hp; scl_cfg_vratio = v.vr;
    if (v.fs_pre) begin
      scl_i_frame_start = 1'b1;
      @(posedge clk); #1;
      scl_i_frame_start = 1'b0;
    end
    for (int t = 0; t < v.len + DLY + 4; t++) begin
      scl_i_data_en     = (t < v.len);
      scl_i_frame_start = (t == v.fs_t);
      if (t == v.chg_t) scl_cfg_hratio = v.chg_hr;
      @(posedge clk); #1;
      if (scl_o_data_en) begin
        j = t - DLY;
        if (j < 0 || j > 31) stray++;
        else mask[j] = 1'b1;
      end
      if (scl_o_line_end) begin le_cnt++; le_t = t; end
      if (t == DLY) keep_s = scl_o_line_keep;
      for (int i = 0; i < TAPS; i++)
        if (en_tap[i] !== ((t - i >= 0) && (t - i < v.len))) tap_err++;
    end
    scl_i_frame_start = 1'b0;
    chk("data_mask", id, mask, v.exp_mask);
    chk("stray_out", id, stray, 0);
    chk("line_keep", id, {31'd0, keep_s}, {31'd0, v.exp_keep});
    chk("line_end_cnt", id, le_cnt, 1);
    chk("line_end_pos", id, le_t, v.len + DLY);
    chk("tap_err", id, tap_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int cnt;
    //            mode hr    hp    vr    fsp fs_t len mask          keep
    vecs[0]  = mk(0, 2'd0, 3'd0, 2'd0, 0, -1, 10, 32'h0000_03FF, 1);
    vecs[1]  = mk(1, 2'd2, 3'd2, 2'd0, 0, -1, 12, 32'h0000_0444, 1);
    vecs[2]  = mk(1, 2'd1, 3'd5, 2'd0, 0, -1,  1, 32'h0000_0000, 1);
    vecs[3]  = mk(1, 2'd1, 3'd5, 2'd0, 0, -1,  6, 32'h0000_002A, 1);
    vecs[4]  = mk(1, 2'd0, 3'd0, 2'd1, 1, -1,  8, 32'h0000_00FF, 1);
    vecs[5]  = mk(1, 2'd0, 3'd0, 2'd1, 0, -1,  8, 32'h0000_0000, 0);
    vecs[6]  = mk(1, 2'd0, 3'd0, 2'd1, 0, -1,  8, 32'h0000_00FF, 1);
    vecs[7]  = mk(1, 2'd0, 3'd0, 2'd1, 0, -1,  8, 32'h0000_0000, 0);
    vecs[8]  = mk(1, 2'd0, 3'd0, 2'd1, 0, -1,  1, 32'h0000_0001, 1);
    vecs[9]  = mk(1, 2'd0, 3'd0, 2'd1, 0, -1,  8, 32'h0000_0000, 0);
    vecs[10] = mk(1, 2'd3, 3'd7, 2'd0, 0, -1, 16, 32'h0000_8080, 1);
    vecs[11] = mk(1, 2'd3, 3'd3, 2'd0, 0, -1, 20, 32'h0008_0808, 1);
    vecs[12] = mk(1, 2'd0, 3'd5, 2'd0, 0, -1,  5, 32'h0000_001F, 1);
    vecs[13] = mk(1, 2'd0, 3'd3, 2'd0, 0, -1, 16, 32'h0000_FFFF, 1);
    vecs[13].chg_t = DLY + 4; vecs[13].chg_hr = 2'd3;
    vecs[14] = mk(1, 2'd3, 3'd3, 2'd0, 0, -1, 16, 32'h0000_0808, 1);
    vecs[15] = mk(1, 2'd0, 3'd0, 2'd1, 1, -1,  4, 32'h0000_000F, 1);
    vecs[16] = mk(1, 2'd0, 3'd0, 2'd1, 0, DLY + 3, 8, 32'h0000_00F0, 0);
    vecs[17] = mk(1, 2'd0, 3'd0, 2'd1, 0, -1,  8, 32'h0000_0000, 0);
    vecs[18] = mk(1, 2'd0, 3'd0, 2'd1, 0, 4 + DLY, 4, 32'h0000_000F, 1);
    vecs[19] = mk(1, 2'd0, 3'd0, 2'd1, 0, -1,  4, 32'h0000_000F, 1);
    vecs[20] = mk(1, 2'd0, 3'd0, 2'd2, 0, -1,  3, 32'h0000_0000, 0);
    vecs[21] = mk(1, 2'd0, 3'd0, 2'd2, 0, -1,  3, 32'h0000_0000, 0);
    vecs[22] = mk(1, 2'd0, 3'd0, 2'd2, 0, -1,  3, 32'h0000_0000, 0);
    vecs[23] = mk(1, 2'd0, 3'd0, 2'd2, 0, -1,  3, 32'h0000_0007, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", -1, {28'd0, scl_o_data_en, scl_o_line_end, scl_o_line_keep, 1'b0} | {28'd0, en_tap}, 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_outputs", -1, {29'd0, scl_o_data_en, scl_o_line_end, |en_tap}, 32'd0);

    for (int k = 0; k < 24; k++) run_line(vecs[k], k);

    // Reset in the middle of an active burst; vcnt is odd here so a dropped
    // line afterwards would betray a counter that survived the reset.
    scl_cfg_mode = 1'b1; scl_cfg_hratio = 2'd0; scl_cfg_hphase = 3'd0; scl_cfg_vratio = 2'd0;
    scl_i_data_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_active", 100, {30'd0, scl_o_data_en, en_tap[TAPS-1]}, 32'd3);
    rst = 1'b0;
    #2;
    chk("async_reset_clear", 100, {28'd0, scl_o_data_en, scl_o_line_end, scl_o_line_keep, |en_tap}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    scl_i_data_en = 1'b0;
    cnt = 0;
    for (int t = 0; t < DLY + 4; t++) begin
      @(posedge clk); #1;
      if (scl_o_data_en || scl_o_line_end || (|en_tap)) cnt++;
    end
    chk("post_reset_quiet", 100, cnt, 0);
    rv = mk(1, 2'd0, 3'd0, 2'd1, 0, -1, 3, 32'h0000_0007, 1);
    run_line(rv, 101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
